// File: rtl/ibex_acc_pkg.sv
// Shared types and default widths for the accelerator writeback arbiter.
// Dual-writeback splitting is compiled in with IBEX_ACC_DUALWB_EN.
package ibex_acc_pkg;

    localparam int unsigned AccNumReq       = 2;
    localparam int unsigned AccDataWidth    = 32;
    localparam int unsigned AccRegAddrWidth = 5;
    localparam int unsigned AccSrcWidth     = $clog2(AccNumReq);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI
    } acc_wb_state_e;

    typedef struct packed {
        logic [AccRegAddrWidth-1:0] rd;
        logic [AccDataWidth-1:0]    data;
        logic [AccSrcWidth-1:0]     src;
        logic                       last;
    } acc_wb_beat_t;

endpackage

// File: rtl/ibex_acc_rr_arb.sv
// Combinational round-robin picker: first requester strictly after ptr
// (modulo NumReq) wins. The pointer register lives in the caller.
module ibex_acc_rr_arb
    import ibex_acc_pkg::*;
#(
    parameter int unsigned NumReq = AccNumReq
) (
    input  logic [NumReq-1:0]         req,
    input  logic [$clog2(NumReq)-1:0] ptr,
    output logic [NumReq-1:0]         gnt,
    output logic [$clog2(NumReq)-1:0] gnt_idx,
    output logic                      gnt_any
);

    localparam int unsigned IdxW = $clog2(NumReq);

    // Scan candidates ptr+1 .. ptr+NumReq, keeping the first valid one
    always_comb begin
        logic [IdxW-1:0] cand;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int unsigned i = 1; i <= NumReq; i++) begin
            cand = IdxW'((32'(ptr) + i) % NumReq);
            if (!gnt_any && req[cand]) begin
                gnt_any   = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ibex_acc_wb_arbiter.sv
// Shares the core accelerator writeback channel between NumReq response
// ports with round-robin arbitration and a registered writeback beat.
// Define IBEX_ACC_DUALWB_EN to split dual-writeback responses into two
// beats (rd, then rd+1); otherwise every response is a single final beat.
module ibex_acc_wb_arbiter
    import ibex_acc_pkg::*;
#(
    parameter int unsigned NumReq       = AccNumReq,
    parameter int unsigned DataWidth    = AccDataWidth,
    parameter int unsigned RegAddrWidth = AccRegAddrWidth
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumReq-1:0]              rsp_valid_i,
    output logic [NumReq-1:0]              rsp_ready_o,
    input  logic [NumReq*RegAddrWidth-1:0] rsp_rd_i,
    input  logic [NumReq*2*DataWidth-1:0]  rsp_data_i,
    input  logic [NumReq-1:0]              rsp_dualwb_i,
    output logic                           wb_valid_o,
    input  logic                           wb_ready_i,
    output logic [RegAddrWidth-1:0]        wb_rd_o,
    output logic [DataWidth-1:0]           wb_data_o,
    output logic [$clog2(NumReq)-1:0]      wb_src_o,
    output logic                           wb_last_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    acc_wb_state_e         state_q, state_d;
    logic [IdxW-1:0]       ptr_q;
    logic [IdxW-1:0]       src_q;
    logic [RegAddrWidth-1:0] rd_q;
    logic [DataWidth-1:0]  lo_q;

    logic [NumReq-1:0]     gnt;
    logic [IdxW-1:0]       gnt_idx;
    logic                  gnt_any;
    logic                  last_hs;
    logic                  load;
    logic                  capture;

`ifdef IBEX_ACC_DUALWB_EN
    logic [DataWidth-1:0]  hi_q;
    logic                  dual_q;

    // Final-beat handshake derived from state, not from wb_last_o, to keep
    // the capture path free of a loop through the output process.
    assign last_hs = wb_ready_i &
                     (((state_q == LO) && !dual_q) || (state_q == HI));
`else
    logic                  unused_in;

    assign unused_in = ^{rsp_dualwb_i, rsp_data_i};
    assign last_hs   = wb_ready_i && (state_q == LO);
`endif

    ibex_acc_rr_arb #(
        .NumReq (NumReq)
    ) u_rr_arb (
        .req     (rsp_valid_i),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign load    = (state_q == IDLE) || last_hs;
    assign capture = load && gnt_any && !rst_i;

    // Pop strobe to the granted requester in the capture cycle only
    assign rsp_ready_o = capture ? gnt : '0;
    assign wb_src_o    = src_q;

    // Beat outputs per state and next-state selection
    always_comb begin
        state_d    = state_q;
        wb_valid_o = 1'b0;
        wb_rd_o    = rd_q;
        wb_data_o  = lo_q;
        wb_last_o  = 1'b0;

        case (state_q)
            LO: begin
                wb_valid_o = 1'b1;
`ifdef IBEX_ACC_DUALWB_EN
                wb_last_o  = !dual_q;
                if (wb_ready_i && dual_q) begin
                    state_d = HI;
                end
`else
                wb_last_o  = 1'b1;
`endif
            end
`ifdef IBEX_ACC_DUALWB_EN
            HI: begin
                wb_valid_o = 1'b1;
                wb_rd_o    = rd_q + RegAddrWidth'(1);
                wb_data_o  = hi_q;
                wb_last_o  = 1'b1;
            end
`endif
            default: ;
        endcase

        if (load) begin
            state_d = gnt_any ? LO : IDLE;
        end
    end

    // State, pointer and captured response registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= IdxW'(NumReq - 1);
            src_q   <= '0;
            rd_q    <= '0;
            lo_q    <= '0;
`ifdef IBEX_ACC_DUALWB_EN
            hi_q    <= '0;
            dual_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (capture) begin
                ptr_q  <= gnt_idx;
                src_q  <= gnt_idx;
                rd_q   <= rsp_rd_i[gnt_idx*RegAddrWidth +: RegAddrWidth];
                lo_q   <= rsp_data_i[gnt_idx*2*DataWidth +: DataWidth];
`ifdef IBEX_ACC_DUALWB_EN
                hi_q   <= rsp_data_i[gnt_idx*2*DataWidth+DataWidth +: DataWidth];
                dual_q <= rsp_dualwb_i[gnt_idx];
`endif
            end
        end
    end

endmodule

// File: tb/tb_ibex_acc_wb_arbiter.sv
// Self-checking bench for ibex_acc_wb_arbiter. Requesters are per-port
// queues; the reference model is a queue of expected writeback beats plus
// the index of the last granted port. Honours IBEX_ACC_DUALWB_EN.
module tb_ibex_acc_wb_arbiter;
    import ibex_acc_pkg::*;

    localparam int NR = 2;
`ifdef IBEX_ACC_DUALWB_EN
    localparam bit DualEn = 1'b1;
`else
    localparam bit DualEn = 1'b0;
`endif

    logic             clk;
    logic             rst_i;
    logic [NR-1:0]    rsp_valid_i;
    logic [NR-1:0]    rsp_ready_o;
    logic [NR*5-1:0]  rsp_rd_i;
    logic [NR*64-1:0] rsp_data_i;
    logic [NR-1:0]    rsp_dualwb_i;
    logic             wb_valid_o;
    logic             wb_ready_i;
    logic [4:0]       wb_rd_o;
    logic [31:0]      wb_data_o;
    logic [0:0]       wb_src_o;
    logic             wb_last_o;

    ibex_acc_wb_arbiter #(
        .NumReq       (NR),
        .DataWidth    (32),
        .RegAddrWidth (5)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .rsp_valid_i  (rsp_valid_i),
        .rsp_ready_o  (rsp_ready_o),
        .rsp_rd_i     (rsp_rd_i),
        .rsp_data_i   (rsp_data_i),
        .rsp_dualwb_i (rsp_dualwb_i),
        .wb_valid_o   (wb_valid_o),
        .wb_ready_i   (wb_ready_i),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .wb_src_o     (wb_src_o),
        .wb_last_o    (wb_last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dual;
    } rsp_t;

    rsp_t         req_q[NR][$];
    acc_wb_beat_t beats[$];
    int           last_gnt;
    int           gnt_log[$];
    int           vec_cnt;
    int           err_cnt;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input int p, input logic [4:0] rd, input logic [31:0] lo,
                        input logic [31:0] hi, input logic dual);
        rsp_t r;
        r.rd = rd; r.lo = lo; r.hi = hi; r.dual = dual;
        req_q[p].push_back(r);
    endtask

    task automatic drive();
        for (int p = 0; p < NR; p++) begin
            if (req_q[p].size() > 0) begin
                rsp_valid_i[p]          = 1'b1;
                rsp_rd_i[p*5 +: 5]      = req_q[p][0].rd;
                rsp_data_i[p*64 +: 64]  = {req_q[p][0].hi, req_q[p][0].lo};
                rsp_dualwb_i[p]         = req_q[p][0].dual;
            end else begin
                rsp_valid_i[p]          = 1'b0;
                rsp_rd_i[p*5 +: 5]      = '0;
                rsp_data_i[p*64 +: 64]  = '0;
                rsp_dualwb_i[p]         = 1'b0;
            end
        end
    endtask

    function automatic int pick();
        for (int i = 1; i <= NR; i++) begin
            int c;
            c = (last_gnt + i) % NR;
            if (req_q[c].size() > 0) return c;
        end
        return -1;
    endfunction

    // One clock: drive, check at negedge, advance model, pop after posedge
    task automatic tick();
        int            g;
        logic [NR-1:0] exp_rdy;
        bit            cap;
        bit            hs;
        acc_wb_beat_t  b;
        drive();
        @(negedge clk);
        g       = -1;
        exp_rdy = '0;
        cap     = (beats.size() == 0) || (wb_ready_i && beats[0].last);
        if (rst_i) cap = 1'b0;
        if (cap) begin
            g = pick();
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        check_eq("rsp_ready", rsp_ready_o, exp_rdy);
        check_eq("wb_valid", wb_valid_o, beats.size() > 0);
        if (beats.size() > 0) begin
            check_eq("wb_rd", wb_rd_o, beats[0].rd);
            check_eq("wb_data", wb_data_o, beats[0].data);
            check_eq("wb_src", wb_src_o, beats[0].src);
            check_eq("wb_last", wb_last_o, beats[0].last);
        end
        hs = (beats.size() > 0) && wb_ready_i;
        if (rst_i) begin
            beats.delete();
            last_gnt = NR - 1;
        end else begin
            if (hs) void'(beats.pop_front());
            if (g >= 0) begin
                b.rd   = req_q[g][0].rd;
                b.data = req_q[g][0].lo;
                b.src  = g[0:0];
                b.last = !(DualEn && req_q[g][0].dual);
                beats.push_back(b);
                if (DualEn && req_q[g][0].dual) begin
                    b.rd   = 5'((req_q[g][0].rd + 1) % 32);
                    b.data = req_q[g][0].hi;
                    b.last = 1'b1;
                    beats.push_back(b);
                end
                last_gnt = g;
                gnt_log.push_back(g);
            end
        end
        @(posedge clk);
        #1;
        if (rst_i) begin
            for (int p = 0; p < NR; p++) req_q[p].delete();
        end else if (g >= 0) begin
            void'(req_q[g].pop_front());
        end
    endtask

    initial begin
        vec_cnt      = 0;
        err_cnt      = 0;
        last_gnt     = NR - 1;
        rst_i        = 1'b1;
        wb_ready_i   = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_wb_valid", wb_valid_o, 0);
        check_eq("rst_rsp_ready", rsp_ready_o, 0);
        check_eq("rst_wb_rd", wb_rd_o, 0);
        check_eq("rst_wb_data", wb_data_o, 0);
        check_eq("rst_wb_src", wb_src_o, 0);
        check_eq("rst_wb_last", wb_last_o, 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Single response from port 0, one-cycle latency
        wb_ready_i = 1'b1;
        push(0, 5'd5, 32'hA5A5A5A5, 32'h0, 1'b0);
        repeat (3) tick();

        // Both ports continuously valid: strict alternation, no bubbles
        gnt_log.delete();
        for (int k = 0; k < 4; k++) begin
            push(0, 5'(k), 32'h1000 + k, 32'h0, 1'b0);
            push(1, 5'(k + 16), 32'h2000 + k, 32'h0, 1'b0);
        end
        repeat (10) tick();
        check_eq("alt_count", gnt_log.size(), 8);
        for (int i = 1; i < gnt_log.size(); i++)
            check_eq("alt_order", gnt_log[i], gnt_log[i-1] ^ 1);

        // Dual response on port 1, port 0 waits behind both beats
        push(1, 5'd7, 32'h11111111, 32'h22222222, 1'b1);
        tick();
        push(0, 5'd3, 32'h33333333, 32'h0, 1'b0);
        repeat (5) tick();

        // Sink stall with port 1 rising while port 0 is held
        push(0, 5'd12, 32'hCAFEF00D, 32'h0, 1'b0);
        tick();
        wb_ready_i = 1'b0;
        push(1, 5'd13, 32'hBEEFBEEF, 32'h0, 1'b0);
        push(0, 5'd14, 32'h0BADF00D, 32'h0, 1'b0);
        repeat (5) tick();
        wb_ready_i = 1'b1;
        repeat (5) tick();

        // rd=31 dual wraps to x0 on the second beat; rd=0 passes through
        push(1, 5'd31, 32'h31313131, 32'h00000000, 1'b1);
        push(0, 5'd0, 32'h0000ABCD, 32'h0000DCBA, 1'b0);
        repeat (5) tick();

        // Reset while the high beat is presented
        repeat (4) tick();
        push(1, 5'd9, 32'h99999999, 32'hAAAAAAAA, 1'b1);
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        gnt_log.delete();
        push(1, 5'd21, 32'h21212121, 32'h0, 1'b0);
        push(0, 5'd20, 32'h20202020, 32'h0, 1'b0);
        repeat (4) tick();
        check_eq("post_rst_first_gnt", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);

        // Randomized traffic with random sink back-pressure
        for (int n = 0; n < 500; n++) begin
            for (int p = 0; p < NR; p++) begin
                if ($urandom_range(0, 3) == 0 && req_q[p].size() < 3)
                    push(p, ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31)),
                         $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
            wb_ready_i = ($urandom_range(0, 9) < 7);
            tick();
        end

        wb_ready_i = 1'b1;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
